// File: rtl/phy_ble_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phy_ble_pkg
// Description : Shared constants and helpers for the BLE PHY header path.
// Revision    : 1.0  initial release
// ============================================================================
package phy_ble_pkg;

    localparam int REP_FACTOR = 3;
    localparam int HDR_AD     = 7;
    localparam int HDR_MEM    = 128;
    localparam int HDR_ERRW   = 8;

    // Majority decision for a completed triplet given its count of ones.
    function automatic logic rep_majority(input logic [1:0] ones);
        return (ones >= 2'd2);
    endfunction

    // A triplet is non-unanimous when its ones count is neither 0 nor 3.
    function automatic logic rep_disagree(input logic [1:0] ones);
        return (ones == 2'd1) || (ones == 2'd2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/repdec_fifo_ble.sv
`default_nettype none
// ============================================================================
// Module      : repdec_fifo_ble
// Description : Bit-wide FIFO with registered read port for decoded bits.
// Revision    : 1.0  initial release
// ============================================================================
module repdec_fifo_ble #(
    parameter int AD  = 7,
    parameter int MEM = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic wr_en,
    input  logic wr_data,
    input  logic rd_en,
    output logic data_out,
    output logic valid_out,
    output logic empty,
    output logic full,
    output logic wr_drop
);

    localparam logic [AD:0] c_MEM_OCC = (AD + 1)'(MEM);

    logic          r_mem [MEM];
    logic [AD-1:0] r_wr_ptr;
    logic [AD-1:0] r_rd_ptr;
    logic [AD:0]   r_occ;
    logic          r_data_out;
    logic          r_valid_out;

    logic w_rd_acc;
    logic w_wr_acc;

    assign empty     = (r_occ == '0);
    assign full      = (r_occ == c_MEM_OCC);
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;

    // A read in the same cycle frees a slot, so a write at full is still taken.
    assign w_rd_acc = rd_en & ~empty;
    assign w_wr_acc = wr_en & (~full | w_rd_acc);
    assign wr_drop  = wr_en & full & ~w_rd_acc;

    always_ff @(posedge clk) begin
        if (!reset && !clear && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because MEM is exactly 2**AD.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_data_out  <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/repetition_decoder_ble.sv
`default_nettype none
// ============================================================================
// Module      : repetition_decoder_ble
// Description : Rate-1/3 majority-vote repetition decoder with output FIFO.
// Revision    : 1.0  initial release
// ============================================================================
module repetition_decoder_ble #(
    parameter int AD   = phy_ble_pkg::HDR_AD,
    parameter int MEM  = phy_ble_pkg::HDR_MEM,
    parameter int ERRW = phy_ble_pkg::HDR_ERRW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            valid_in,
    input  logic            data_in,
    input  logic            re,
    output logic            data_out,
    output logic            valid_out,
    output logic            empty,
    output logic            full,
    output logic [ERRW-1:0] err_count,
    output logic            overflow
);

    import phy_ble_pkg::*;

    localparam logic [1:0] c_TRI_LAST = 2'(REP_FACTOR - 1);

    logic [1:0]      r_tri_cnt;
    logic [1:0]      r_ones_cnt;
    logic [ERRW-1:0] r_err_count;
    logic            r_overflow;

    logic [1:0] w_sum;
    logic       w_done;
    logic       w_bit;
    logic       w_wr_drop;

    assign w_sum     = r_ones_cnt + {1'b0, data_in};
    assign w_done    = valid_in && (r_tri_cnt == c_TRI_LAST);
    assign w_bit     = rep_majority(w_sum);
    assign err_count = r_err_count;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_tri_cnt   <= '0;
            r_ones_cnt  <= '0;
            r_err_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_done) begin
                r_tri_cnt  <= '0;
                r_ones_cnt <= '0;
                if (rep_disagree(w_sum) && (r_err_count != '1)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end else if (valid_in) begin
                r_tri_cnt  <= r_tri_cnt + 1'b1;
                r_ones_cnt <= w_sum;
            end
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    repdec_fifo_ble #(
        .AD  (AD),
        .MEM (MEM)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .wr_en     (w_done),
        .wr_data   (w_bit),
        .rd_en     (re),
        .data_out  (data_out),
        .valid_out (valid_out),
        .empty     (empty),
        .full      (full),
        .wr_drop   (w_wr_drop)
    );

endmodule
`default_nettype wire

// File: tb/tb_repetition_decoder_ble.sv
`default_nettype none
// ============================================================================
// Module      : tb_repetition_decoder_ble
// Description : Scoreboard bench for the repetition decoder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_repetition_decoder_ble;

    localparam int c_MEM = 128;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       valid_in = 1'b0;
    logic       data_in = 1'b0;
    logic       re = 1'b0;
    logic       data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic [7:0] err_count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit q[$];
    bit sb[$];
    int m_tri = 0;
    int m_ones = 0;
    int m_err = 0;
    bit m_ovf = 0;
    bit m_vout = 0;
    bit m_dout = 0;

    always #5 clk = ~clk;

    repetition_decoder_ble dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .re        (re),
        .data_out  (data_out),
        .valid_out (valid_out),
        .empty     (empty),
        .full      (full),
        .err_count (err_count),
        .overflow  (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic vin, input logic din, input logic rd,
                        input logic clr, input logic rst);
        int  sum;
        valid_in = vin;
        data_in  = din;
        re       = rd;
        clear    = clr;
        reset    = rst;
        if (rst || clr) begin
            q.delete();
            sb.delete();
            m_tri = 0; m_ones = 0; m_err = 0; m_ovf = 0; m_vout = 0; m_dout = 0;
        end else begin
            m_vout = 0;
            if (rd && q.size() > 0) begin
                sb.push_back(q.pop_front());
                m_vout = 1;
            end
            if (vin) begin
                if (m_tri == 2) begin
                    sum = m_ones + int'(din);
                    if ((sum == 1 || sum == 2) && m_err < 255) m_err++;
                    if (q.size() < c_MEM) q.push_back(sum >= 2);
                    else m_ovf = 1;
                    m_tri = 0;
                    m_ones = 0;
                end else begin
                    m_tri++;
                    m_ones += int'(din);
                end
            end
        end
        @(posedge clk);
        #1;
        check_val("valid_out", 32'(valid_out), 32'(m_vout));
        if (m_vout) begin
            if (sb.size() == 0) check_val("sb_underflow", 32'd1, 32'd0);
            else m_dout = sb.pop_front();
        end
        check_val("data_out", 32'(data_out), 32'(m_dout));
        check_val("empty", 32'(empty), 32'(q.size() == 0));
        check_val("full", 32'(full), 32'(q.size() == c_MEM));
        check_val("err_count", 32'(err_count), 32'(m_err));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        valid_in = 1'b0;
        re       = 1'b0;
        clear    = 1'b0;
        reset    = 1'b0;
    endtask

    // Three coded bits; rd is asserted alongside the final bit.
    task automatic send_tri(input logic a, input logic b, input logic c, input logic rd);
        step(1'b1, a, 1'b0, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
        step(1'b1, c, rd, 1'b0, 1'b0);
    endtask

    task automatic rd_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic b0;
        logic bx;

        // Reset state
        step(0, 0, 0, 0, 1);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_dout", 32'(data_out), 32'd0);

        // Clean stream 111 000 111
        send_tri(1, 1, 1, 0);
        send_tri(0, 0, 0, 0);
        send_tri(1, 1, 1, 0);
        rd_n(3);
        step(0, 0, 0, 0, 0);
        check_val("t1_err", 32'(err_count), 32'd0);
        check_val("t1_empty", 32'(empty), 32'd1);

        // Disagreeing triplets, with a gap inside one triplet
        send_tri(1, 1, 0, 0);
        send_tri(0, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        send_tri(0, 1, 0, 0);
        rd_n(4);
        check_val("t2_err4", 32'(err_count), 32'd4);

        // Noisy triplets saturate the error counter
        for (int i = 0; i < 300; i++) begin
            b0 = 1'($urandom_range(0, 1));
            bx = 1'($urandom_range(0, 1));
            send_tri(b0, ~b0, bx, 1);
        end
        rd_n(2);
        check_val("t2_err_sat", 32'(err_count), 32'd255);

        // Fill, overflow, drain
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < c_MEM; i++) begin
            b0 = 1'($urandom_range(0, 1));
            send_tri(b0, b0, b0, 0);
        end
        check_val("t3_full", 32'(full), 32'd1);
        send_tri(1, 1, 0, 0);
        check_val("t3_ovf", 32'(overflow), 32'd1);
        rd_n(c_MEM);
        check_val("t3_empty", 32'(empty), 32'd1);

        // Write at full with a same-cycle read
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < c_MEM; i++) send_tri(1'(i % 3 == 0), 1'(i % 3 == 0), 1'(i % 3 == 0), 0);
        send_tri(0, 1, 1, 1);
        check_val("t4_full", 32'(full), 32'd1);
        check_val("t4_ovf", 32'(overflow), 32'd0);
        rd_n(c_MEM);
        check_val("t4_last_bit", 32'(data_out), 32'd1);

        // Clear discards a partial triplet; inputs in the clear cycle are ignored
        send_tri(1, 1, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        check_val("t5_clr_empty", 32'(empty), 32'd1);
        send_tri(0, 0, 0, 0);
        rd_n(2);
        check_val("t5_err", 32'(err_count), 32'd0);

        // Read while empty holds data_out
        send_tri(1, 1, 1, 0);
        rd_n(1);
        rd_n(2);
        check_val("t6_hold", 32'(data_out), 32'd1);

        // Reset mid-stream
        send_tri(1, 0, 1, 0);
        send_tri(1, 1, 1, 0);
        rd_n(1);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 1);
        check_val("t6_rst_dout", 32'(data_out), 32'd0);
        check_val("t6_rst_err", 32'(err_count), 32'd0);
        send_tri(0, 0, 0, 0);
        rd_n(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/repetition_decoder_ble.md
# repetition_decoder_ble

Rate-1/3 repetition decoder for the BLE PHY receive header path. It is the receive-side counterpart of the transmit header repetition encoder. It accepts the serial coded bit stream, groups bits into triplets, and resolves each triplet to one bit by majority vote. Decoded bits are buffered in a bit-wide FIFO until the downstream header parser pulls them with a read-enable. It also reports how many triplets disagreed and whether the buffer overflowed.

## Interface
Parameters:
- AD, 7, FIFO address width.
- MEM, 128, FIFO depth in decoded bits. Must equal 2**AD.
- ERRW, 8, width of the disagreement counter.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  reset is synchronous and active-high.
- clear  input  1  synchronous frame restart; realigns the triplet phase and empties the FIFO.
- valid_in  input  1  data_in carries a coded bit this cycle.
- data_in  input  1  coded bit.
- re  input  1  downstream request for one decoded bit.
- data_out  output  1  decoded bit; holds its value between reads.
- valid_out  output  1  data_out was updated by the read on the previous edge.
- empty  output  1  FIFO holds no decoded bits.
- full  output  1  FIFO holds MEM decoded bits.
- err_count  output  ERRW  triplets with non-unanimous bits; saturates at all-ones.
- overflow  output  1  sticky; a decoded bit was dropped because the FIFO was full.

## Operation
- Triplet collector: tri_cnt counts 0..2 and ones_cnt counts 0..2. Both advance only when valid_in is high.
- On valid_in with tri_cnt<2: tri_cnt+1, ones_cnt+data_in.
- On valid_in with tri_cnt==2: sum = ones_cnt + data_in (2-bit, max 3). Decoded bit = (sum>=2).
  - tri_cnt and ones_cnt return to 0.
  - If sum is 1 or 2, err_count increments, saturating at all-ones.
- Write: a completed triplet with full low writes ram[wr_ptr] and increments wr_ptr, which wraps modulo MEM. If full is high, the bit is dropped, overflow is set to 1 and the pointers are unchanged.
- Read: re with empty low loads data_out from ram[rd_ptr], increments rd_ptr (wraps) and sets valid_out to 1. re with empty high is ignored and valid_out goes to 0. With re low, valid_out goes to 0 and data_out holds.
- Occupancy counter is AD+1 bits wide.
  - empty = (occ==0); full = (occ==MEM).
  - A simultaneous accepted write and read leaves occ unchanged.
- Priority: reset > clear > normal operation.
- clear has the same effect as reset on every register and output. valid_in and re in the clear cycle are ignored.
- The RAM array itself is not reset.

## Timing
- Reset values:
  - data_out 0, valid_out 0, empty 1, full 0, err_count 0, overflow 0.
  - tri_cnt 0, ones_cnt 0, wr_ptr 0, rd_ptr 0, occ 0.
- Decode latency: the decoded bit is written on the edge that samples the third coded bit. empty falls after that same edge.
- The earliest useful re is asserted in the following cycle. data_out and valid_out update on the edge that samples re, giving 1-cycle read latency.
- A bit written on edge N is not readable by a re sampled on edge N, because empty is still high for that edge.
- Gaps in valid_in do not break a triplet; the phase is kept indefinitely until clear or reset.
- At full, with a completing triplet and an accepted re in the same cycle: the read is taken first, so the write is accepted, occ stays at MEM and overflow is not set.
- Pointer wrap from MEM-1 to 0 is seamless; data ordering is preserved.
- Reset or clear mid-triplet discards the partial triplet. The next valid_in is treated as triplet bit 0.
- Continuous re at one read per cycle drains a full FIFO in MEM cycles, with valid_out high each cycle.

## Structure
- Shared package phy_ble_pkg holds:
  - REP_FACTOR = 3.
  - Default AD/MEM for header buffers.
  - ERRW.
- Sub-module repdec_fifo_ble contains the RAM, wr_ptr, rd_ptr, occ, empty, full and read register.
- The top level holds the triplet collector, majority logic, err_count and overflow.

## Test plan
- Coded stream 111 000 111 then 3 re pulses -> data_out sequence 1,0,1 with valid_out high 1 cycle after each re; err_count=0; empty=1 at the end.
- Triplets 110, 001, 101, 010 -> decoded 1,0,1,0; err_count=4. Then 300 noisy triplets with ERRW=8 -> err_count saturates at 255.
- 128 triplets with no reads -> full=1. A 129th triplet -> overflow=1, occ stays 128. Then 128 reads return the first 128 bits in order.
- Fill to full, then complete a triplet in the same cycle as re -> overflow stays 0, full stays 1; the new bit is returned last.
- Two coded bits then clear, then 000 -> one decoded bit 0; the partial triplet is discarded; err_count=0.
- re while empty -> valid_out=0 and data_out unchanged. Assert reset mid-stream -> all outputs return to their reset values on the next edge.
